matmul_input_feeder: RTL and testbench
======================================

# matmul_input_feeder

Skewed input streamer for the weight/input-stationary systolic matmul flow. It snapshots an input matrix on `start` and drives it into the array rows as a diagonal wavefront. Row r lags row r-1 by one clock, and each element is held for HOLD clocks to match the double-buffered traditional_mac. It is the producer-side counterpart of the output-collection path and sits between the input buffer and `systolic_matmul_fsm`'s row inputs.

## Interface
- WORD_SIZE, 16, bits per element
- ROWS, 4, array rows (one feed lane per row)
- VECS, 4, input vectors per matmul run
- HOLD, 2, clocks each element is held; HOLD >= 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  run request, sampled only in IDLE
- in_matrix  in  VECS*ROWS*WORD_SIZE  element IN[v][r] at bits [(v*ROWS+r)*WORD_SIZE +: WORD_SIZE]
- feed_data  out  ROWS*WORD_SIZE  lane r at bits [r*WORD_SIZE +: WORD_SIZE]
- feed_valid  out  ROWS  per-lane valid
- busy  out  1  high in FEED and DONE
- done  out  1  one-cycle pulse at end of run

## Operation
- States:
  - IDLE: waits for `start`.
  - FEED: streams the snapshot.
  - DONE: one cycle, then IDLE.
- IDLE & start=1 at a clock edge:
  - Copy in_matrix into the internal snapshot.
  - Clear the run counter t to 0.
  - Enter FEED.
- IDLE & start=0: stay in IDLE.
- FEED: t increments every clock. Lane r is active when r <= t < r + VECS*HOLD.
- Active lane r presents element v = (t - r) / HOLD. Implement this with per-lane lag/hold/index counters, not a divider.
- Inactive lanes drive feed_valid[r]=0 and feed_data lane = 0.
- Transition FEED -> DONE after the last active cycle, t_last = ROWS-2 + VECS*HOLD.
- DONE: done=1, busy=1, all lanes invalid; next state is IDLE unconditionally.
- `start` is ignored in FEED and DONE. No queuing.
- in_matrix changes after the capture edge have no effect on the current run.
- Counter widths: t needs $clog2(ROWS+VECS*HOLD)+1 bits. Per-lane vector index needs $clog2(VECS)+1 bits. No counter wraps within a run.

## Timing
- Reset values: feed_data=0, feed_valid=0, busy=0, done=0, state=IDLE. Counters are cleared; the snapshot is not reset.
- rst has priority over all transitions. rst asserted mid-FEED forces every output to its reset value in the next cycle and discards the run.
- Latency: start sampled at edge E. Cycle t=0 is the cycle after E, with feed_valid[0]=1 and lane 0 = IN[0][0].
- Lane r, element v is valid for cycles t = r + v*HOLD through r + v*HOLD + HOLD - 1.
- Run length: FEED lasts ROWS-1 + VECS*HOLD cycles, then 1 DONE cycle, then at least 1 IDLE cycle before the next FEED.
- With start held high continuously, back-to-back runs are separated by exactly one IDLE cycle.
- All outputs are registered or decoded only from registered state. There is no combinational path from `start` or in_matrix to outputs.

## Test plan
- Defaults (ROWS=4, VECS=4, HOLD=2), IN[v][r] = 16*v + r, pulse start for one cycle:
  - Lane 2 is valid at t=2..9, with data 0x0002 at t=2,3, 0x0012 at t=4,5, 0x0022 at t=6,7, 0x0032 at t=8,9.
  - Lane 3's last valid cycle is t=10.
  - done=1 only at t=11; busy=1 at t=0..11.
- in_matrix rewritten to all 0xFFFF at t=3 of a run: streamed values still match the snapshot. A second run afterwards streams 0xFFFF on every valid slot.
- start held high for 30 cycles: the first run reaches done at t=11. The next run's t=0 occurs exactly 2 cycles after the done cycle. Extra start cycles during FEED/DONE never restart t.
- rst asserted at t=5 for one cycle: the next cycle has feed_valid=0, feed_data=0, busy=0, done=0. A subsequent start yields the full, correct run from t=0.
- HOLD=1, VECS=3, ROWS=4:
  - Lane r is valid at t=r..r+2, and its data changes every cycle.
  - done occurs at t=6.
  - At t=2, lanes 0, 1, 2 are valid carrying IN[2][0], IN[1][1], IN[0][2].
- Boundary: ROWS=1, VECS=1, HOLD=1. Lane 0 is valid only at t=0, and done occurs at t=1.

Source files
------------

// File: rtl/matmul_input_feeder.sv
// Skewed input streamer for the systolic matmul array: snapshots a VECS x ROWS
// matrix on start and feeds it as a diagonal wavefront, each element held HOLD clocks.
module matmul_input_feeder #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int VECS      = 4,
    parameter int HOLD      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [VECS*ROWS*WORD_SIZE-1:0] in_matrix,
    output logic [ROWS*WORD_SIZE-1:0]      feed_data,
    output logic [ROWS-1:0]                feed_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int T_W    = $clog2(ROWS + VECS*HOLD) + 1;
    localparam int LAG_W  = $clog2(ROWS) + 1;
    localparam int HOLD_W = $clog2(HOLD) + 1;
    localparam int IDX_W  = $clog2(VECS) + 1;
    localparam int T_LAST = ROWS - 2 + VECS*HOLD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [T_W-1:0]       t;
    logic [LAG_W-1:0]     lag      [ROWS];
    logic [HOLD_W-1:0]    hold_cnt [ROWS];
    logic [IDX_W-1:0]     idx      [ROWS];
    logic                 fin      [ROWS];
    logic [WORD_SIZE-1:0] snap_p0  [VECS][ROWS];

    logic capture;
    assign capture = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FEED;
            FEED:    if (t == T_W'(T_LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: the snapshot isolates the run from later in_matrix changes.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int v = 0; v < VECS; v++) begin
                for (int r = 0; r < ROWS; r++) begin
                    snap_p0[v][r] <= in_matrix[(v*ROWS + r)*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    // Lane r waits r clocks (lag), then walks its column, advancing the index every HOLD clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            t <= '0;
            for (int r = 0; r < ROWS; r++) begin
                lag[r]      <= '0;
                hold_cnt[r] <= '0;
                idx[r]      <= '0;
                fin[r]      <= 1'b0;
            end
        end else if (capture) begin
            t <= '0;
            for (int r = 0; r < ROWS; r++) begin
                lag[r]      <= LAG_W'(r);
                hold_cnt[r] <= '0;
                idx[r]      <= '0;
                fin[r]      <= 1'b0;
            end
        end else if (state == FEED) begin
            t <= t + 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                if (lag[r] != '0) begin
                    lag[r] <= lag[r] - 1'b1;
                end else if (!fin[r]) begin
                    if (hold_cnt[r] == HOLD_W'(HOLD - 1)) begin
                        hold_cnt[r] <= '0;
                        if (idx[r] == IDX_W'(VECS - 1)) begin
                            fin[r] <= 1'b1;
                        end else begin
                            idx[r] <= idx[r] + 1'b1;
                        end
                    end else begin
                        hold_cnt[r] <= hold_cnt[r] + 1'b1;
                    end
                end
            end
        end
    end

    // Output stage: decoded purely from registered state, snapshot and lane counters.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        feed_data  = '0;
        feed_valid = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ((state == FEED) && (lag[r] == '0) && !fin[r]) begin
                feed_valid[r] = 1'b1;
                for (int v = 0; v < VECS; v++) begin
                    if (idx[r] == IDX_W'(v)) begin
                        feed_data[r*WORD_SIZE +: WORD_SIZE] = snap_p0[v][r];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_input_feeder.sv
// Bench for matmul_input_feeder: three configurations checked every cycle against a
// run-time model (t since capture, snapshot array) plus hand-computed literal expectations.
module tb_matmul_input_feeder;

    localparam int CR [3] = '{4, 4, 1};
    localparam int CV [3] = '{4, 3, 1};
    localparam int CH [3] = '{2, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  st;
    logic [15:0] mat [3][4][4];

    logic [255:0] im0;
    logic [191:0] im1;
    logic [15:0]  im2;
    logic [63:0]  fd0, fd1;
    logic [15:0]  fd2;
    logic [3:0]   fv0, fv1;
    logic [0:0]   fv2;
    logic [2:0]   by, dn;

    logic [15:0] fdk [3][4];
    logic        fvk [3][4];

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    int          mt [3] = '{-1, -1, -1};
    logic [15:0] msnap [3][4][4];

    always_comb begin
        im0 = '0;
        im1 = '0;
        for (int v = 0; v < 4; v++)
            for (int r = 0; r < 4; r++)
                im0[(v*4 + r)*16 +: 16] = mat[0][v][r];
        for (int v = 0; v < 3; v++)
            for (int r = 0; r < 4; r++)
                im1[(v*4 + r)*16 +: 16] = mat[1][v][r];
        im2 = mat[2][0][0];
    end

    matmul_input_feeder #(.WORD_SIZE(16), .ROWS(4), .VECS(4), .HOLD(2)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(st[0]), .in_matrix(im0),
        .feed_data(fd0), .feed_valid(fv0), .busy(by[0]), .done(dn[0]));
    matmul_input_feeder #(.WORD_SIZE(16), .ROWS(4), .VECS(3), .HOLD(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(st[1]), .in_matrix(im1),
        .feed_data(fd1), .feed_valid(fv1), .busy(by[1]), .done(dn[1]));
    matmul_input_feeder #(.WORD_SIZE(16), .ROWS(1), .VECS(1), .HOLD(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(st[2]), .in_matrix(im2),
        .feed_data(fd2), .feed_valid(fv2), .busy(by[2]), .done(dn[2]));

    always_comb begin
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 4; r++) begin
                fdk[k][r] = '0;
                fvk[k][r] = 1'b0;
            end
        for (int r = 0; r < 4; r++) begin
            fdk[0][r] = fd0[r*16 +: 16];
            fvk[0][r] = fv0[r];
            fdk[1][r] = fd1[r*16 +: 16];
            fvk[1][r] = fv1[r];
        end
        fdk[2][0] = fd2;
        fvk[2][0] = fv2[0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: mt is cycles since the capture edge (-1 when idle); a run ends after its done cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                mt[k] <= -1;
            end else if (mt[k] < 0) begin
                if (st[k]) begin
                    mt[k] <= 0;
                    for (int v = 0; v < 4; v++)
                        for (int r = 0; r < 4; r++)
                            msnap[k][v][r] <= mat[k][v][r];
                end
            end else if (mt[k] + 1 > CR[k] - 2 + CV[k]*CH[k] + 1) begin
                mt[k] <= -1;
            end else begin
                mt[k] <= mt[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        int t, tl;
        logic act;
        logic [15:0] ed;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                t  = mt[k];
                tl = CR[k] - 2 + CV[k]*CH[k];
                chk($sformatf("i%0d busy t=%0d", k, t), 32'(by[k]), 32'(t >= 0));
                chk($sformatf("i%0d done t=%0d", k, t), 32'(dn[k]), 32'(t == tl + 1));
                for (int r = 0; r < CR[k]; r++) begin
                    act = (t >= r) && (t < r + CV[k]*CH[k]);
                    ed  = act ? msnap[k][(t - r)/CH[k]][r] : 16'h0;
                    chk($sformatf("i%0d lane%0d valid t=%0d", k, r, t), 32'(fvk[k][r]), 32'(act));
                    chk($sformatf("i%0d lane%0d data t=%0d", k, r, t), 32'(fdk[k][r]), 32'(ed));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the run's t=0 cycle.
    task automatic pulse(input int k);
        @(negedge clk);
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    initial begin
        rst_v = 3'b111;
        st    = 3'b000;
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++)
                for (int r = 0; r < 4; r++)
                    mat[k][v][r] = 16'(16*v + r);
        mat[2][0][0] = 16'h00AB;
        step(3);
        rst_v  = 3'b000;
        chk_en = 1'b1;
        chk("reset busy", 32'(by), 32'(0));
        chk("reset done", 32'(dn), 32'(0));
        chk("reset valid", 32'(fv0), 32'(0));
        chk("reset data", 32'(fd0[31:0]), 32'(0));

        // Default run, input rewritten mid-run
        pulse(0);
        chk("run1 t0 valid", 32'(fv0), 32'h1);
        step(2);
        chk("run1 t2 valid", 32'(fv0), 32'h7);
        chk("run1 t2 lane2", 32'(fd0[47:32]), 32'h0002);
        step(1);
        for (int v = 0; v < 4; v++)
            for (int r = 0; r < 4; r++)
                mat[0][v][r] = 16'hFFFF;
        step(1);
        chk("run1 t4 lane2", 32'(fd0[47:32]), 32'h0012);
        step(5);
        chk("run1 t9 lane2", 32'(fd0[47:32]), 32'h0032);
        step(1);
        chk("run1 t10 valid", 32'(fv0), 32'h8);
        chk("run1 t10 lane3", 32'(fd0[63:48]), 32'h0033);
        step(1);
        chk("run1 t11 done", 32'(dn[0]), 32'h1);
        chk("run1 t11 valid", 32'(fv0), 32'h0);
        step(1);
        chk("run1 t12 busy", 32'(by[0]), 32'h0);

        pulse(0);
        chk("run2 t0 lane0", 32'(fd0[15:0]), 32'hFFFF);
        step(12);

        // start held high
        for (int v = 0; v < 4; v++)
            for (int r = 0; r < 4; r++)
                mat[0][v][r] = 16'(16'h0100 + 16*v + r);
        @(negedge clk);
        st[0] = 1'b1;
        step(1);
        chk("held t0 lane0", 32'(fd0[15:0]), 32'h0100);
        step(11);
        chk("held t11 done", 32'(dn[0]), 32'h1);
        step(1);
        chk("held gap busy", 32'(by[0]), 32'h0);
        step(1);
        chk("held rerun busy", 32'(by[0]), 32'h1);
        chk("held rerun valid", 32'(fv0), 32'h1);
        step(14);
        st[0] = 1'b0;
        step(20);

        // Reset mid-run
        pulse(0);
        step(5);
        rst_v[0] = 1'b1;
        step(1);
        rst_v[0] = 1'b0;
        chk("midrst valid", 32'(fv0), 32'h0);
        chk("midrst data", 32'(fd0[31:0]), 32'h0);
        chk("midrst busy", 32'(by[0]), 32'h0);
        chk("midrst done", 32'(dn[0]), 32'h0);
        pulse(0);
        chk("postrst t0 lane0", 32'(fd0[15:0]), 32'h0100);
        step(13);

        // HOLD=1, VECS=3
        pulse(1);
        step(2);
        chk("h1 t2 valid", 32'(fv1), 32'h7);
        chk("h1 t2 lane0", 32'(fd1[15:0]), 32'h0020);
        chk("h1 t2 lane1", 32'(fd1[31:16]), 32'h0011);
        chk("h1 t2 lane2", 32'(fd1[47:32]), 32'h0002);
        step(3);
        chk("h1 t5 valid", 32'(fv1), 32'h8);
        chk("h1 t5 lane3", 32'(fd1[63:48]), 32'h0023);
        step(1);
        chk("h1 t6 done", 32'(dn[1]), 32'h1);
        step(2);

        // ROWS=VECS=HOLD=1
        pulse(2);
        chk("b1 t0 valid", 32'(fv2), 32'h1);
        chk("b1 t0 data", 32'(fd2), 32'h00AB);
        step(1);
        chk("b1 t1 valid", 32'(fv2), 32'h0);
        chk("b1 t1 done", 32'(dn[2]), 32'h1);
        step(2);
        chk("b1 idle busy", 32'(by[2]), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
